// File: rtl/pixel_row_serializer.sv
// Row-to-byte serializer: ROW RGB pixels out as R,G,B bytes, pixel 0 first; 1 cycle capture-to-first-byte.
// Backpressure: byte_out/eol/eof/line_idx hold while byte_ready is low; row_ready is low for the whole row.
module pixel_row_serializer #(
   parameter int ROW   = 256,
   parameter int WIDTH = 8,
   parameter int LINES = 256
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [ROW*WIDTH*3-1:0]     row_in,
   input  logic                       row_valid,
   output logic                       row_ready,
   output logic [WIDTH-1:0]           byte_out,
   output logic                       byte_valid,
   input  logic                       byte_ready,
   output logic                       eol,
   output logic                       eof,
   output logic [$clog2(LINES)-1:0]   line_idx
);

   localparam int RW    = ROW * WIDTH * 3;
   localparam int TOTAL = 3 * ROW;
   localparam int CW    = $clog2(TOTAL);
   localparam int LW    = $clog2(LINES);

   localparam logic [CW-1:0] LAST_CNT  = CW'(TOTAL - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]    state;
   logic [RW-1:0] shreg;
   logic [CW-1:0] byte_cnt;
   logic          last_byte;

   assign last_byte  = (byte_cnt == LAST_CNT);
   assign byte_valid = (state == SEND);
   assign byte_out   = shreg[RW-1 -: WIDTH];
   assign eol        = (state == SEND) && last_byte;
   assign eof        = eol && (line_idx == LAST_LINE);

   // The shift register drains to zero as bytes leave, so byte_out reads 0 whenever idle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         row_ready <= 1'b0;
         shreg     <= '0;
         byte_cnt  <= '0;
         line_idx  <= '0;
      end else if (state == IDLE) begin
         if (row_valid && row_ready) begin
            shreg     <= row_in;
            byte_cnt  <= '0;
            state     <= SEND;
            row_ready <= 1'b0;
         end else begin
            row_ready <= 1'b1;
         end
      end else if (byte_ready) begin
         shreg <= shreg << WIDTH;
         if (last_byte) begin
            state     <= IDLE;
            row_ready <= 1'b1;
            byte_cnt  <= '0;
            line_idx  <= (line_idx == LAST_LINE) ? '0 : line_idx + LW'(1);
         end else begin
            byte_cnt <= byte_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Random and directed row streams through a small (4x2) and a wide (256x4) serializer against a byte-queue model.
module tb_pixel_row_serializer;

   localparam int RA = 4;
   localparam int LA = 2;
   localparam int RB = 256;
   localparam int LB = 4;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;
   logic RST;

   logic [RA*24-1:0] row_a;
   logic rv_a, rr_a, bv_a, br_a, eol_a, eof_a;
   logic [7:0] bo_a;
   logic [0:0] li_a;

   logic [RB*24-1:0] row_b;
   logic rv_b, rr_b, bv_b, br_b, eol_b, eof_b;
   logic [7:0] bo_b;
   logic [1:0] li_b;

   pixel_row_serializer #(.ROW(RA), .WIDTH(8), .LINES(LA)) dut_a (
      .CLK(CLK), .RST(RST), .row_in(row_a), .row_valid(rv_a), .row_ready(rr_a),
      .byte_out(bo_a), .byte_valid(bv_a), .byte_ready(br_a), .eol(eol_a), .eof(eof_a),
      .line_idx(li_a));

   pixel_row_serializer #(.ROW(RB), .WIDTH(8), .LINES(LB)) dut_b (
      .CLK(CLK), .RST(RST), .row_in(row_b), .row_valid(rv_b), .row_ready(rr_b),
      .byte_out(bo_b), .byte_valid(bv_b), .byte_ready(br_b), .eol(eol_b), .eof(eof_b),
      .line_idx(li_b));

   typedef struct packed {
      logic [7:0] b;
      logic       eol;
      logic       eof;
      logic [1:0] line;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int total = 0, bad = 0;
   int acc_a = 0, acc_b = 0, eols_b = 0, eofs_b = 0;
   int line_a = 0, line_b = 0;
   logic pend_a = 1'b0;
   logic [7:0] pbyte_a;
   logic peol_a;
   int pat[6] = '{1, 0, 0, 1, 0, 1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a row is a list of pixels; each pixel yields R, G, B in that order.
   task automatic push_row_a(input logic [RA*24-1:0] d);
      logic [23:0] px;
      exp_t e;
      for (int p = 0; p < RA; p++) begin
         px = d[RA*24-1-24*p -: 24];
         for (int c = 0; c < 3; c++) begin
            e.b    = (c == 0) ? px[23:16] : (c == 1) ? px[15:8] : px[7:0];
            e.eol  = (p == RA-1) && (c == 2);
            e.eof  = e.eol && (line_a == LA-1);
            e.line = 2'(line_a);
            qa.push_back(e);
         end
      end
      line_a = (line_a + 1) % LA;
   endtask

   function automatic logic [RA*24-1:0] rand_row_a();
      return {$urandom, $urandom, $urandom};
   endfunction

   // mode 0: ready=1, 1: fixed pattern, 2: random ready, 3: random ready + row offered while busy
   task automatic run_row_a(input logic [RA*24-1:0] d, input int mode, input int abort_after);
      int cyc, start;
      cyc = 0;
      while (rr_a !== 1'b1 && cyc < 20) begin
         @(posedge CLK); #1; cyc++;
      end
      chk("row_ready_idle", 32'(rr_a), 32'd1);
      push_row_a(d);
      start = acc_a;
      row_a = d;
      rv_a  = 1'b1;
      br_a  = 1'b1;
      @(posedge CLK); #1;
      rv_a = 1'b0;
      chk("first_byte_valid", 32'(bv_a), 32'd1);
      chk("first_byte", 32'(bo_a), 32'(d[RA*24-1 -: 8]));
      chk("row_ready_busy", 32'(rr_a), 32'd0);
      cyc = 0;
      while (qa.size() > 0 && cyc < 500) begin
         if (abort_after > 0 && acc_a - start == abort_after) break;
         case (mode)
            0: br_a = 1'b1;
            1: br_a = (pat[cyc % 6] != 0);
            default: br_a = 1'($urandom);
         endcase
         if (mode == 3) begin
            rv_a  = cyc[0];
            row_a = rand_row_a();
         end
         @(posedge CLK); #1;
         cyc++;
         if (qa.size() > 0) chk("row_ready_busy", 32'(rr_a), 32'd0);
      end
      rv_a = 1'b0;
      if (abort_after == 0) begin
         chk("row_drained", 32'(qa.size()), 32'd0);
         chk("row_ready_after_row", 32'(rr_a), 32'd1);
         chk("line_idx_after_row", 32'(li_a), 32'(line_a));
         chk("bytes_per_row", 32'(acc_a - start), 32'(3*RA));
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         pend_a = 1'b0;
      end else begin
         if (pend_a) begin
            chk("hold_valid", 32'(bv_a), 32'd1);
            chk("hold_byte", 32'(bo_a), 32'(pbyte_a));
            chk("hold_eol", 32'(eol_a), 32'(peol_a));
         end
         if (!bv_a) begin
            if (eol_a || eof_a) chk("eol_eof_idle", {30'd0, eol_a, eof_a}, 32'd0);
         end else if (br_a) begin
            if (qa.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_byte_a: got %0h expected none", bo_a);
            end else begin
               ea = qa.pop_front();
               chk("byte_a", 32'(bo_a), 32'(ea.b));
               chk("eol_a", 32'(eol_a), 32'(ea.eol));
               chk("eof_a", 32'(eof_a), 32'(ea.eof));
               chk("line_a", 32'(li_a), 32'(ea.line[0]));
            end
            acc_a++;
         end
         pend_a  = bv_a && !br_a;
         pbyte_a = bo_a;
         peol_a  = eol_a;
      end
   end

   always @(negedge CLK) begin
      if (!RST && bv_b && br_b) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte_b: got %0h expected none", bo_b);
         end else begin
            eb = qb.pop_front();
            chk("byte_b", 32'(bo_b), 32'(eb.b));
            chk("eol_b", 32'(eol_b), 32'(eb.eol));
            chk("eof_b", 32'(eof_b), 32'(eb.eof));
            chk("line_b", 32'(li_b), 32'(eb.line));
         end
         acc_b++;
         if (eol_b) eols_b++;
         if (eof_b) eofs_b++;
      end
   end

   task automatic run_frame_b();
      int cyc;
      exp_t e;
      for (int r = 0; r < LB; r++) begin
         cyc = 0;
         while (rr_b !== 1'b1 && cyc < 20) begin
            @(posedge CLK); #1; cyc++;
         end
         chk("row_ready_b", 32'(rr_b), 32'd1);
         for (int k = 0; k < 3*RB; k++) begin
            row_b[RB*24-1-8*k -: 8] = 8'((r + k) % 256);
            e.b    = 8'((r + k) % 256);
            e.eol  = (k == 3*RB-1);
            e.eof  = e.eol && (line_b == LB-1);
            e.line = 2'(line_b);
            qb.push_back(e);
         end
         line_b = (line_b + 1) % LB;
         rv_b = 1'b1;
         @(posedge CLK); #1;
         rv_b = 1'b0;
         cyc = 0;
         while (qb.size() > 0 && cyc < 5000) begin
            br_b = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
            cyc++;
         end
         chk("row_drained_b", 32'(qb.size()), 32'd0);
      end
   endtask

   initial begin
      logic [RA*24-1:0] r1, r2;
      RST = 1'b1;
      rv_a = 1'b0; br_a = 1'b0; row_a = '0;
      rv_b = 1'b0; br_b = 1'b0; row_b = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_row_ready", 32'(rr_a), 32'd0);
      chk("rst_byte_valid", 32'(bv_a), 32'd0);
      chk("rst_byte_out", 32'(bo_a), 32'd0);
      chk("rst_eol_eof", {30'd0, eol_a, eof_a}, 32'd0);
      chk("rst_line_idx", 32'(li_a), 32'd0);
      chk("rst_row_ready_b", 32'(rr_b), 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("row_ready_after_reset", 32'(rr_a), 32'd1);

      r1 = 96'h112233_445566_778899_AABBCC;
      r2 = 96'h010203_040506_070809_0A0B0C;
      run_row_a(r1, 0, 0);
      run_row_a(r2, 0, 0);
      run_row_a(r1, 1, 0);
      run_row_a(rand_row_a(), 3, 0);
      for (int i = 0; i < 6; i++) run_row_a(rand_row_a(), i % 4, 0);

      run_row_a(rand_row_a(), 0, 5);
      RST  = 1'b1;
      br_a = 1'b0;
      @(posedge CLK); #1;
      chk("midrst_byte_valid", 32'(bv_a), 32'd0);
      chk("midrst_line_idx", 32'(li_a), 32'd0);
      chk("midrst_byte_out", 32'(bo_a), 32'd0);
      chk("midrst_row_ready", 32'(rr_a), 32'd0);
      qa.delete();
      line_a = 0;
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("row_ready_after_midrst", 32'(rr_a), 32'd1);
      run_row_a(r2, 2, 0);
      run_row_a(rand_row_a(), 1, 0);

      run_frame_b();
      chk("bytes_b", 32'(acc_b), 32'(3*RB*LB));
      chk("eol_pulses_b", 32'(eols_b), 32'(LB));
      chk("eof_pulses_b", 32'(eofs_b), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
